// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: lockout (MODE=0) or integrate (MODE=1) per instance, with rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchroniser on every sw_in bit (adds 2 cycles of latency).
module debounce_bank #(
    parameter int                WIDTH      = 4,
    parameter int                CNT_W      = 16,
    parameter logic [CNT_W-1:0]  STABLE_CNT = 16'd4,
    parameter int                MODE       = 0,
    parameter logic              RST_VAL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = STABLE_CNT - CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             out_q, out_d;
            logic             rise_q, rise_d;
            logic             fall_q, fall_d;
            logic             s;

`ifdef DEBOUNCE_SYNC_EN
            logic sync1_q, sync2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q <= RST_VAL;
                    sync2_q <= RST_VAL;
                end else begin
                    sync1_q <= sw_in[gi];
                    sync2_q <= sync1_q;
                end
            end

            assign s = sync2_q;
`else
            assign s = sw_in[gi];
`endif

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                out_d   = out_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (s != out_q) begin
                            cnt_d = RELOAD;
                            if (MODE == 0) begin
                                // Lockout: pass the new level now, then ignore the input.
                                out_d   = s;
                                rise_d  = s;
                                fall_d  = ~s;
                                state_d = ST_HOLD;
                            end else begin
                                state_d = ST_CHECK;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        // A matching sample means the change was a glitch; the counter reloads on re-entry.
                        if (s == out_q) begin
                            state_d = ST_IDLE;
                        end else if (cnt_q == '0) begin
                            out_d   = s;
                            rise_d  = s;
                            fall_d  = ~s;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    out_q   <= RST_VAL;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    out_q   <= out_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign out[gi]  = out_q;
            assign rise[gi] = rise_q;
            assign fall[gi] = fall_q;
            assign busy[gi] = (state_q != ST_IDLE);
        end
    endgenerate

endmodule
